// File: rtl/flit_pkg.sv
// Shared definitions for the flit packetizer: flit field layout, tail marker,
// FSM state encoding and a small flit packing helper.
package flit_pkg;

  localparam int FLIT_W  = 48;
  localparam int CTRL_HI = 47;
  localparam int CTRL_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 16;
  localparam int CSUM_HI = 15;
  localparam int CSUM_LO = 0;

  // ctrl value that marks the closing flit of a packet
  localparam logic [15:0] TAIL_MARK = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  // Assemble a flit from its three 16-bit fields.
  function automatic logic [FLIT_W-1:0] pack_flit(input logic [15:0] ctrl,
                                                  input logic [15:0] data,
                                                  input logic [15:0] csum);
    logic [FLIT_W-1:0] f;
    f                  = '0;
    f[CTRL_HI:CTRL_LO] = ctrl;
    f[DATA_HI:DATA_LO] = data;
    f[CSUM_HI:CSUM_LO] = csum;
    return f;
  endfunction

endpackage

// File: rtl/flit_packetizer_if.sv
// Word-in / flit-out stream bundle of the packetizer. The slave modport is the
// packetizer itself; the master modport is whoever sources words and sinks flits.
interface flit_packetizer_if;
  import flit_pkg::*;

  logic [15:0]       data_in;
  logic              data_valid;
  logic              data_last;
  logic [3:0]        dest_id;
  logic              data_ready;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              flit_ready;

  modport slave (
    input  data_in,
    input  data_valid,
    input  data_last,
    input  dest_id,
    input  flit_ready,
    output data_ready,
    output flit_out,
    output flit_valid
  );

  modport master (
    output data_in,
    output data_valid,
    output data_last,
    output dest_id,
    output flit_ready,
    input  data_ready,
    input  flit_out,
    input  flit_valid
  );

endinterface

// File: rtl/flit_packetizer.sv
// Packs a valid/ready stream of 16-bit words into 48-bit flits
// {ctrl, payload, running checksum}. A packet closes with a tail flit
// (ctrl = TAIL_MARK) on a sender-marked last word, on reaching the maximum
// packet length, or after an idle timeout (empty tail with payload 0).
module flit_packetizer
  import flit_pkg::*;
#(
  parameter int PKT_MAX_WORDS = 16,
  parameter int IDLE_TIMEOUT  = 32
) (
  input  logic                clk,
  input  logic                reset,
  flit_packetizer_if.slave    io_bus,
  output logic [15:0]         o_pkt_count,
  output logic                o_busy
);

  localparam int              CNT_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0]      LAST_IDX = 8'(PKT_MAX_WORDS - 1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(IDLE_TIMEOUT);

  state_t            r_state, w_state_next;
  logic [7:0]        r_idx, w_idx_next;
  logic [15:0]       r_csum, w_csum_next;
  logic [3:0]        r_dest, w_dest_next;
  logic [CNT_W-1:0]  r_idle_cnt, w_idle_cnt_next;
  logic [FLIT_W-1:0] r_flit, w_flit_next;
  logic              r_flit_valid, w_flit_valid_next;
  logic [15:0]       r_pkt_count, w_pkt_count_next;

  logic              w_slot_free;
  logic              w_data_ready;
  logic              w_accept;
  logic              w_in_open;
  logic [7:0]        w_idx_word;
  logic [15:0]       w_csum_word;
  logic [3:0]        w_dest_word;
  logic              w_is_tail;
  logic [15:0]       w_ctrl_word;

  // The output register can take a new flit when empty or being drained.
  assign w_slot_free  = ~r_flit_valid | io_bus.flit_ready;
  assign w_data_ready = w_slot_free & (r_state != CLOSE);
  assign w_accept     = io_bus.data_valid & w_data_ready;
  assign w_in_open    = (r_state == OPEN);

  // Fields of the flit built from the word presented this cycle; the first
  // word of a packet restarts index and checksum and samples the destination.
  assign w_idx_word  = w_in_open ? (r_idx + 8'd1) : 8'd0;
  assign w_csum_word = (w_in_open ? r_csum : 16'h0000) + io_bus.data_in;
  assign w_dest_word = w_in_open ? r_dest : io_bus.dest_id;
  assign w_is_tail   = io_bus.data_last | (w_idx_word == LAST_IDX);
  assign w_ctrl_word = w_is_tail ? TAIL_MARK : {4'h0, w_dest_word, w_idx_word};

  // Next-state and datapath decisions for the packet FSM and output register.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_csum_next       = r_csum;
    w_dest_next       = r_dest;
    w_idle_cnt_next   = r_idle_cnt;
    w_flit_next       = r_flit;
    w_flit_valid_next = r_flit_valid & ~io_bus.flit_ready;
    w_pkt_count_next  = r_pkt_count;

    case (r_state)
      CLOSE: begin
        // Empty tail: payload 0, checksum carried over from the open packet.
        if (w_slot_free) begin
          w_flit_next       = pack_flit(TAIL_MARK, 16'h0000, r_csum);
          w_flit_valid_next = 1'b1;
          w_pkt_count_next  = r_pkt_count + 16'd1;
          w_idx_next        = 8'd0;
          w_csum_next       = 16'h0000;
          w_idle_cnt_next   = '0;
          w_state_next      = IDLE;
        end
      end

      default: begin
        if (w_accept) begin
          // An accepted word always wins over a timeout hitting this cycle.
          w_flit_next       = pack_flit(w_ctrl_word, io_bus.data_in, w_csum_word);
          w_flit_valid_next = 1'b1;
          w_idle_cnt_next   = '0;
          w_dest_next       = w_dest_word;
          if (w_is_tail) begin
            w_pkt_count_next = r_pkt_count + 16'd1;
            w_idx_next       = 8'd0;
            w_csum_next      = 16'h0000;
            w_state_next     = IDLE;
          end else begin
            w_idx_next       = w_idx_word;
            w_csum_next      = w_csum_word;
            w_state_next     = OPEN;
          end
        end else if (w_in_open) begin
          // Idle counting keeps going under backpressure, but the close
          // only starts once the output slot is free.
          if ((r_idle_cnt >= TO_CNT) && w_data_ready) begin
            w_idle_cnt_next = '0;
            w_state_next    = CLOSE;
          end else if (r_idle_cnt < TO_CNT) begin
            w_idle_cnt_next = r_idle_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Packet context, idle counter, output flit register and tail counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= 8'd0;
      r_csum       <= 16'h0000;
      r_dest       <= 4'h0;
      r_idle_cnt   <= '0;
      r_flit       <= '0;
      r_flit_valid <= 1'b0;
      r_pkt_count  <= 16'h0000;
    end else begin
      r_idx        <= w_idx_next;
      r_csum       <= w_csum_next;
      r_dest       <= w_dest_next;
      r_idle_cnt   <= w_idle_cnt_next;
      r_flit       <= w_flit_next;
      r_flit_valid <= w_flit_valid_next;
      r_pkt_count  <= w_pkt_count_next;
    end
  end

  assign io_bus.data_ready = w_data_ready;
  assign io_bus.flit_out   = r_flit;
  assign io_bus.flit_valid = r_flit_valid;
  assign o_pkt_count       = r_pkt_count;
  assign o_busy            = w_in_open;

endmodule
